// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped transmit front end for the uart_tx serializer.
// CPU writes to TXDATA are queued in a circular FIFO; a small sequencer pops
// one byte at a time and hands it to uart_tx with a single-cycle start pulse,
// then follows uart_tx's busy handshake before sending the next byte.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_wbusy,
  output logic        mem_rbusy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            enable;

  logic [1:0]      reg_sel;
  logic            bus_wr, bus_rd;
  logic            full, empty;
  logic            push, pop, flush;
  logic            active;
  logic [31:0]     rdata_mux;

  // Address bits below the word and the upper write-data byte lanes carry no
  // meaning for this block.
  logic            unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

  assign reg_sel   = mem_addr[3:2];
  assign bus_wr    = sel & (|mem_wmask);
  assign bus_rd    = sel & mem_rstrb;

  // Full/empty come only from the registered count, so a pop in the same
  // cycle never releases a stall early.
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);

  assign mem_wbusy = bus_wr & (reg_sel == REG_TXDATA) & full;
  assign mem_rbusy = 1'b0;
  assign push      = bus_wr & (reg_sel == REG_TXDATA) & ~full;
  assign flush     = bus_wr & (reg_sel == REG_CTRL) & mem_wdata[1];
  assign active    = (state_q != ST_IDLE) | tx_busy;

  // Sequencer next-state logic; pop is issued only on the IDLE->START step.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && !empty && !tx_busy) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START:     state_d = tx_busy ? ST_WAIT_DONE : ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy)  state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, start pulse and the registered byte handed to uart_tx.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q  <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state_q  <= state_d;
      tx_start <= pop;
      if (pop) tx_data <= fifo_mem[rd_ptr];
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset; occupancy is tracked by
    // the pointers and count, so stale entries are never observed.
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  // FIFO pointers and occupancy; flush overrides any push/pop that edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // CTRL.enable register; the flush bit is an action and is not stored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable <= 1'b1;
    end else if (bus_wr && reg_sel == REG_CTRL) begin
      enable <= mem_wdata[0];
    end
  end

  // Read-data selection from pre-edge state.
  always_comb begin
    rdata_mux = 32'h0;
    unique case (reg_sel)
      REG_STATUS: rdata_mux = {16'h0, 8'(count), 5'h0, empty, full, active};
      REG_CTRL:   rdata_mux = {31'h0, enable};
      default:    rdata_mux = 32'h0;
    endcase
  end

  // Registered read data, loaded only on a read strobe and held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rdata <= 32'h0;
    end else if (bus_rd) begin
      mem_rdata <= rdata_mux;
    end
  end

endmodule
